// File: rtl/parking_tracker.sv
// Parking-lot front end: samples slot sensors, counts arrivals per work hour into
// an 8x16 car-track RAM, tracks the rush-hour window and scrolls the RAM out after the day ends.
module parking_tracker #(
    parameter int unsigned SCROLL_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  slot_sensor,
    input  logic        hour_tick,
    output logic [2:0]  parking_status,
    output logic [3:0]  work_hour,
    output logic        work_day_expired,
    output logic [3:0]  rush_start,
    output logic        rush_start_exist,
    output logic [3:0]  rush_end,
    output logic        rush_end_exist,
    output logic [2:0]  car_track_ram_addr,
    output logic [15:0] car_track_ram_out
);

    localparam int unsigned SW = (SCROLL_CYCLES > 2) ? $clog2(SCROLL_CYCLES) : 1;

    typedef enum logic {
        COUNTING,
        EXPIRED
    } state_t;

    state_t         r_state;
    logic [15:0]    r_count;
    logic [SW-1:0]  r_scroll;
    logic [15:0]    r_ram [8];

    logic [2:0]     w_new;
    logic [1:0]     w_pop;
    logic [16:0]    w_sum;
    logic [15:0]    w_sat;
    logic           w_ram_we;
    logic           w_scroll_wrap;

    always_comb begin
        w_new         = slot_sensor & ~parking_status;
        w_pop         = {1'b0, w_new[0]} + {1'b0, w_new[1]} + {1'b0, w_new[2]};
        w_sum         = {1'b0, r_count} + {15'b0, w_pop};
        w_sat         = w_sum[16] ? '1 : w_sum[15:0];
        w_ram_we      = (r_state == COUNTING) && hour_tick;
        w_scroll_wrap = (r_scroll == SW'(SCROLL_CYCLES - 1));
    end

    // Storage carries no reset; every entry is written before the readout reaches it.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[work_hour[2:0]] <= w_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= COUNTING;
            r_count            <= '0;
            r_scroll           <= '0;
            parking_status     <= '0;
            work_hour          <= '0;
            work_day_expired   <= 1'b0;
            rush_start         <= '0;
            rush_start_exist   <= 1'b0;
            rush_end           <= '0;
            rush_end_exist     <= 1'b0;
            car_track_ram_addr <= '0;
            car_track_ram_out  <= '0;
        end else begin
            parking_status    <= slot_sensor;
            car_track_ram_out <= r_ram[car_track_ram_addr];

            case (r_state)
                COUNTING: begin
                    if (slot_sensor == 3'b111 && !rush_start_exist) begin
                        rush_start       <= work_hour;
                        rush_start_exist <= 1'b1;
                    end
                    if (rush_start_exist && !rush_end_exist && slot_sensor == 3'b000) begin
                        rush_end       <= work_hour;
                        rush_end_exist <= 1'b1;
                    end

                    if (hour_tick) begin
                        r_count <= '0;
                        if (work_hour < 4'd7) begin
                            work_hour <= work_hour + 4'd1;
                        end else begin
                            work_day_expired   <= 1'b1;
                            r_state            <= EXPIRED;
                            car_track_ram_addr <= 3'd7;
                            r_scroll           <= '0;
                        end
                    end else begin
                        r_count <= w_sat;
                    end
                end

                EXPIRED: begin
                    // Address walks downward and wraps 0 -> 7 naturally in 3 bits.
                    if (w_scroll_wrap) begin
                        r_scroll           <= '0;
                        car_track_ram_addr <= car_track_ram_addr - 3'd1;
                    end else begin
                        r_scroll <= r_scroll + SW'(1);
                    end
                end

                default: r_state <= COUNTING;
            endcase
        end
    end

endmodule

// File: tb/tb_parking_tracker.sv
// Self-checking bench for parking_tracker: directed vector table, saturation and
// reset corner cases, and randomized days checked against a behavioural model.
module tb_parking_tracker;

    localparam int unsigned SCROLL = 4;

    logic        clk;
    logic        rst_n;
    logic [2:0]  slot_sensor;
    logic        hour_tick;
    logic [2:0]  parking_status;
    logic [3:0]  work_hour;
    logic        work_day_expired;
    logic [3:0]  rush_start;
    logic        rush_start_exist;
    logic [3:0]  rush_end;
    logic        rush_end_exist;
    logic [2:0]  car_track_ram_addr;
    logic [15:0] car_track_ram_out;

    parking_tracker #(.SCROLL_CYCLES(SCROLL)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .slot_sensor        (slot_sensor),
        .hour_tick          (hour_tick),
        .parking_status     (parking_status),
        .work_hour          (work_hour),
        .work_day_expired   (work_day_expired),
        .rush_start         (rush_start),
        .rush_start_exist   (rush_start_exist),
        .rush_end           (rush_end),
        .rush_end_exist     (rush_end_exist),
        .car_track_ram_addr (car_track_ram_addr),
        .car_track_ram_out  (car_track_ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of one work day
    int m_prev, m_cnt, m_hour, m_exp, m_rs, m_rse, m_re, m_ree;
    int m_ram [8];

    typedef struct {
        logic [2:0] s;
        logic       t;
        logic [2:0] st;
        int         hr;
        int         ex;
        int         rs;
        int         rse;
        int         re;
        int         ree;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [63:0] all_outs();
        return {27'b0, parking_status, work_hour, work_day_expired, rush_start, rush_start_exist,
                rush_end, rush_end_exist, car_track_ram_addr, car_track_ram_out};
    endfunction

    task automatic cyc(input logic [2:0] s, input logic t);
        slot_sensor = s;
        hour_tick   = t;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_prev = 0; m_cnt = 0; m_hour = 0; m_exp = 0;
        m_rs = 0; m_rse = 0; m_re = 0; m_ree = 0;
    endtask

    task automatic model_step(input int s, input int t);
        if (m_exp == 0) begin
            m_cnt = m_cnt + $countones(s & ~m_prev & 7);
            if (m_cnt > 65535) m_cnt = 65535;
            if (s == 7 && m_rse == 0) begin
                m_rs = m_hour; m_rse = 1;
            end else if (m_rse == 1 && m_ree == 0 && s == 0) begin
                m_re = m_hour; m_ree = 1;
            end
            if (t != 0) begin
                m_ram[m_hour] = m_cnt;
                m_cnt = 0;
                if (m_hour < 7) m_hour++;
                else m_exp = 1;
            end
        end
        m_prev = s;
    endtask

    task automatic do_reset(input logic [2:0] s);
        rst_n       = 1'b0;
        slot_sensor = s;
        hour_tick   = 1'b0;
        #2;
        chk("reset_async_outputs", all_outs(), 64'd0);
        @(posedge clk);
        #1;
        chk("reset_held_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Called right after the expiring edge; checks the scroll order and data for 9 address windows.
    task automatic readout_check(input string tag);
        int a_now, a_prev;
        logic [2:0] s;
        chk({tag, "_addr_start"}, car_track_ram_addr, 64'd7);
        for (int k = 1; k <= 36; k++) begin
            s = 3'($urandom_range(0, 7));
            cyc(s, 1'($urandom_range(0, 1)));
            a_now  = ((7 - k / SCROLL) % 8 + 8) % 8;
            a_prev = ((7 - (k - 1) / SCROLL) % 8 + 8) % 8;
            chk({tag, "_addr"}, car_track_ram_addr, 64'(a_now));
            chk({tag, "_data"}, car_track_ram_out, 64'(m_ram[a_prev]));
            chk({tag, "_status"}, parking_status, 64'(s));
            chk({tag, "_hold"}, {work_hour, work_day_expired, rush_start, rush_start_exist,
                                 rush_end, rush_end_exist},
                64'({4'd7, 1'b1, 4'(m_rs), 1'(m_rse), 4'(m_re), 1'(m_ree)}));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        slot_sensor = 3'b101;
        hour_tick   = 1'b0;

        // Reset with sensors at 101; first cycle after release sees two rising slots.
        do_reset(3'b101);

        vt.push_back('{3'b101, 1'b0, 3'b101, 0, 0, 0, 0, 0, 0});
        vt.push_back('{3'b000, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0});
        vt.push_back('{3'b001, 1'b0, 3'b001, 0, 0, 0, 0, 0, 0});
        vt.push_back('{3'b011, 1'b0, 3'b011, 0, 0, 0, 0, 0, 0});
        vt.push_back('{3'b010, 1'b0, 3'b010, 0, 0, 0, 0, 0, 0});
        vt.push_back('{3'b011, 1'b1, 3'b011, 1, 0, 0, 0, 0, 0});
        vt.push_back('{3'b100, 1'b0, 3'b100, 1, 0, 0, 0, 0, 0});
        vt.push_back('{3'b000, 1'b0, 3'b000, 1, 0, 0, 0, 0, 0});
        vt.push_back('{3'b100, 1'b0, 3'b100, 1, 0, 0, 0, 0, 0});
        vt.push_back('{3'b000, 1'b0, 3'b000, 1, 0, 0, 0, 0, 0});
        vt.push_back('{3'b100, 1'b1, 3'b100, 2, 0, 0, 0, 0, 0});
        vt.push_back('{3'b111, 1'b0, 3'b111, 2, 0, 2, 1, 0, 0});
        vt.push_back('{3'b111, 1'b1, 3'b111, 3, 0, 2, 1, 0, 0});
        vt.push_back('{3'b011, 1'b1, 3'b011, 4, 0, 2, 1, 0, 0});
        vt.push_back('{3'b000, 1'b0, 3'b000, 4, 0, 2, 1, 4, 1});
        vt.push_back('{3'b111, 1'b1, 3'b111, 5, 0, 2, 1, 4, 1});
        vt.push_back('{3'b000, 1'b0, 3'b000, 5, 0, 2, 1, 4, 1});
        vt.push_back('{3'b111, 1'b0, 3'b111, 5, 0, 2, 1, 4, 1});
        vt.push_back('{3'b000, 1'b1, 3'b000, 6, 0, 2, 1, 4, 1});
        vt.push_back('{3'b001, 1'b1, 3'b001, 7, 0, 2, 1, 4, 1});
        vt.push_back('{3'b010, 1'b0, 3'b010, 7, 0, 2, 1, 4, 1});
        vt.push_back('{3'b010, 1'b1, 3'b010, 7, 1, 2, 1, 4, 1});

        foreach (vt[i]) begin
            cyc(vt[i].s, vt[i].t);
            chk($sformatf("vec%0d_status", i), parking_status, 64'(vt[i].st));
            chk($sformatf("vec%0d_hour", i), work_hour, 64'(vt[i].hr));
            chk($sformatf("vec%0d_expired", i), work_day_expired, 64'(vt[i].ex));
            chk($sformatf("vec%0d_rush", i), {rush_start, rush_start_exist, rush_end, rush_end_exist},
                64'({4'(vt[i].rs), 1'(vt[i].rse), 4'(vt[i].re), 1'(vt[i].ree)}));
        end

        m_ram = '{5, 3, 2, 0, 3, 3, 1, 1};
        m_rs = 2; m_rse = 1; m_re = 4; m_ree = 1;
        readout_check("dir_readout");

        // Asynchronous reset in the middle of the readout
        cyc(3'b110, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midreset_outputs", all_outs(), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(3'b000, 1'b0);
        chk("midreset_hour", work_hour, 64'd0);
        chk("midreset_expired", work_day_expired, 64'd0);
        cyc(3'b000, 1'b1);
        chk("midreset_counting", work_hour, 64'd1);

        // Saturation: 21845 * 3 arrivals reach FFFF, three more must not wrap
        do_reset(3'b000);
        for (int i = 0; i < 21845; i++) begin
            cyc(3'b111, 1'b0);
            cyc(3'b000, 1'b0);
        end
        cyc(3'b111, 1'b1);
        chk("sat_hour", work_hour, 64'd1);
        for (int h = 2; h <= 7; h++) begin
            cyc(3'b000, 1'b1);
            chk("sat_tick_hour", work_hour, 64'(h));
        end
        cyc(3'b000, 1'b1);
        chk("sat_expired", work_day_expired, 64'd1);
        m_ram = '{65535, 0, 0, 0, 0, 0, 0, 0};
        m_rs = 0; m_rse = 1; m_re = 0; m_ree = 1;
        readout_check("sat_readout");

        // Randomized days against the model
        for (int d = 0; d < 3; d++) begin
            logic [2:0] s0;
            int cycles;
            s0 = 3'($urandom_range(0, 7));
            do_reset(s0);
            cycles = 0;
            while (m_exp == 0 && cycles < 1000) begin
                int s, t;
                s = (cycles == 0) ? int'(s0) : int'($urandom_range(0, 7));
                t = ($urandom_range(0, 5) == 0) ? 1 : 0;
                model_step(s, t);
                cyc(3'(s), 1'(t));
                chk("rnd_status", parking_status, 64'(s));
                chk("rnd_hour", work_hour, 64'(m_hour));
                chk("rnd_expired", work_day_expired, 64'(m_exp));
                chk("rnd_rush", {rush_start, rush_start_exist, rush_end, rush_end_exist},
                    64'({4'(m_rs), 1'(m_rse), 4'(m_re), 1'(m_ree)}));
                cycles++;
            end
            if (m_exp == 0)
                chk("rnd_day_budget", 64'(cycles), 64'd0);
            else
                readout_check("rnd_readout");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
